// File: rtl/vending_machine_multi_if.sv
// Front-end / actuator bundle for vending_machine_multi: keypad and coin acceptor
// inputs, dispenser and coin-return outputs, plus credit/state observation.
interface vending_machine_multi_if #(
    parameter int SEL_W    = 3,
    parameter int CREDIT_W = 6
) ();
    logic [SEL_W-1:0]    choice;
    logic                coin_valid;
    logic [3:0]          money;
    logic                cancel;
    logic                delivery;
    logic [SEL_W-1:0]    product_id;
    logic                change_valid;
    logic [3:0]          change;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          states;

    modport master (
        output choice, coin_valid, money, cancel,
        input  delivery, product_id, change_valid, change, coin_reject, credit, states
    );

    modport slave (
        input  choice, coin_valid, money, cancel,
        output delivery, product_id, change_valid, change, coin_reject, credit, states
    );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: price table, Rs.5/Rs.10 credit, cancel, timeout, coin-by-coin change.
// Optional sales/refund counters are built when VM_SALES_COUNT_EN is defined.
module vending_machine_multi #(
    parameter int NUM_PRODUCTS   = 4,
    parameter int SEL_W          = 3,
    parameter int CREDIT_W       = 6,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {6'd20, 6'd15, 6'd5, 6'd10},
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    vending_machine_multi_if.slave bus
`ifdef VM_SALES_COUNT_EN
    ,
    output logic [15:0]            sales_count,
    output logic [15:0]            refund_count
`endif
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0] NUM_SEL  = SEL_W'(NUM_PRODUCTS);
    localparam logic [CREDIT_W-1:0] TEN   = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] FIVE  = CREDIT_W'(5);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_COLLECT  = 3'b001,
        ST_DISPENSE = 3'b010,
        ST_CHANGE   = 3'b011
    } state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [SEL_W-1:0]    pid_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                coin_reject_q;

    logic [CREDIT_W-1:0] price_tbl [2**SEL_W];
    logic [CREDIT_W-1:0] price_cur;
    logic [CREDIT_W-1:0] credit_sum_d;
    logic [CREDIT_W-1:0] change_amt;
    logic                coin_legal;
    logic                choice_ok;

    // Unused codes (0 and above NUM_PRODUCTS) map to price 0; they are never latched.
    generate
        for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_price
            if (gi >= 1 && gi <= NUM_PRODUCTS) begin : g_used
                assign price_tbl[gi] = PRICES[gi*CREDIT_W-1 -: CREDIT_W];
            end else begin : g_unused
                assign price_tbl[gi] = '0;
            end
        end
    endgenerate

    assign price_cur    = price_tbl[pid_q];
    assign coin_legal   = bus.coin_valid && (bus.money == 4'b0101 || bus.money == 4'b1010);
    assign credit_sum_d = credit_q + CREDIT_W'(bus.money);
    assign change_amt   = (credit_q >= TEN) ? TEN : FIVE;
    assign choice_ok    = (bus.choice != '0) && (bus.choice <= NUM_SEL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            pid_q         <= '0;
            cnt_q         <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            coin_reject_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    coin_reject_q <= bus.coin_valid;
                    if (choice_ok) begin
                        pid_q    <= bus.choice;
                        credit_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.cancel) begin
                        // Nothing to refund with zero credit, so return straight to IDLE.
                        coin_reject_q <= bus.coin_valid;
                        state_q       <= (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                    end else if (coin_legal) begin
                        credit_q <= credit_sum_d;
                        cnt_q    <= '0;
                        if (credit_sum_d >= price_cur) begin
                            state_q <= ST_DISPENSE;
                        end
                    end else begin
                        coin_reject_q <= bus.coin_valid;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DISPENSE: begin
                    coin_reject_q <= bus.coin_valid;
                    credit_q      <= credit_q - price_cur;
                    state_q       <= (credit_q != price_cur) ? ST_CHANGE : ST_IDLE;
                end
                ST_CHANGE: begin
                    coin_reject_q <= bus.coin_valid;
                    credit_q      <= credit_q - change_amt;
                    if (credit_q <= change_amt) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    credit_q <= '0;
                end
            endcase
        end
    end

    assign bus.delivery     = (state_q == ST_DISPENSE);
    assign bus.product_id   = pid_q;
    assign bus.change_valid = (state_q == ST_CHANGE);
    assign bus.change       = (state_q != ST_CHANGE) ? 4'b0000 :
                              (credit_q >= TEN)      ? 4'b1010 : 4'b0101;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.credit       = credit_q;
    assign bus.states       = state_q;

`ifdef VM_SALES_COUNT_EN
    logic [15:0] sales_q;
    logic [15:0] refund_q;
    logic        refund_evt;

    // Mirrors the COLLECT -> CHANGE transitions above (cancel or timeout with credit held).
    assign refund_evt = (state_q == ST_COLLECT) && (credit_q != '0) &&
                        (bus.cancel || (!coin_legal && cnt_q == CNT_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sales_q  <= '0;
            refund_q <= '0;
        end else begin
            if (state_q == ST_DISPENSE && sales_q != 16'hFFFF) begin
                sales_q <= sales_q + 16'd1;
            end
            if (refund_evt && refund_q != 16'hFFFF) begin
                refund_q <= refund_q + 16'd1;
            end
        end
    end

    assign sales_count  = sales_q;
    assign refund_count = refund_q;
`endif
endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios then random cycles, all checked
// against a transaction-level model (credit arithmetic plus a queue of refund coins).
module tb_vending_machine_multi;
    localparam int NP      = 4;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vending_machine_multi_if #(.SEL_W(3), .CREDIT_W(6)) bus ();

`ifdef VM_SALES_COUNT_EN
    logic [15:0] sales_count;
    logic [15:0] refund_count;
`endif

    vending_machine_multi #(
        .NUM_PRODUCTS   (NP),
        .SEL_W          (3),
        .CREDIT_W       (6),
        .PRICES         ({6'd20, 6'd15, 6'd5, 6'd10}),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef VM_SALES_COUNT_EN
        ,
        .sales_count  (sales_count),
        .refund_count (refund_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    endtask

    // Reference model: phase numbers follow the published state codes.
    int m_phase, m_credit, m_pid, m_idle, m_reject, m_sales, m_refunds;
    int m_q[$];

    function automatic int price_of(int p);
        case (p)
            1: return 10;
            2: return 5;
            3: return 15;
            4: return 20;
            default: return 0;
        endcase
    endfunction

    function automatic int queue_sum();
        int s = 0;
        foreach (m_q[i]) s += m_q[i];
        return s;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_credit = 0; m_pid = 0; m_idle = 0; m_reject = 0;
        m_sales = 0; m_refunds = 0;
        m_q.delete();
    endtask

    task automatic load_change(int amount);
        int v = amount;
        while (v >= 10) begin m_q.push_back(10); v -= 10; end
        if (v == 5) m_q.push_back(5);
        m_credit = 0;
    endtask

    task automatic refund();
        if (m_credit > 0) begin
            $display("txn refund: product %0d credit %0d", m_pid, m_credit);
            load_change(m_credit);
            if (m_refunds < 65535) m_refunds++;
            m_phase = 3;
        end else begin
            $display("txn abandon: product %0d, no credit", m_pid);
            m_phase = 0;
        end
    endtask

    task automatic model_step(int ch, int cv, int mo, int ca);
        bit legal = (cv != 0) && (mo == 5 || mo == 10);
        m_reject = 0;
        case (m_phase)
            0: begin
                m_reject = cv;
                if (ch >= 1 && ch <= NP) begin
                    m_pid = ch; m_credit = 0; m_idle = 0; m_phase = 1;
                end
            end
            1: begin
                if (ca != 0) begin
                    m_reject = cv;
                    refund();
                end else if (legal) begin
                    m_credit += mo;
                    m_idle = 0;
                    if (m_credit >= price_of(m_pid)) m_phase = 2;
                end else begin
                    m_reject = cv;
                    m_idle++;
                    if (m_idle == TIMEOUT) refund();
                end
            end
            2: begin
                int rem = m_credit - price_of(m_pid);
                $display("txn sale: product %0d paid %0d change %0d", m_pid, m_credit, rem);
                if (m_sales < 65535) m_sales++;
                m_reject = cv;
                load_change(rem);
                m_phase = (rem > 0) ? 3 : 0;
            end
            default: begin
                m_reject = cv;
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_outputs();
        check_eq("states", 32'(bus.states), m_phase);
        check_eq("credit", 32'(bus.credit), (m_phase == 3) ? queue_sum() : m_credit);
        check_eq("delivery", 32'(bus.delivery), (m_phase == 2) ? 1 : 0);
        if (m_phase == 2) check_eq("product_id", 32'(bus.product_id), m_pid);
        check_eq("change_valid", 32'(bus.change_valid), (m_phase == 3) ? 1 : 0);
        check_eq("change", 32'(bus.change), (m_phase == 3) ? m_q[0] : 0);
        check_eq("coin_reject", 32'(bus.coin_reject), m_reject);
`ifdef VM_SALES_COUNT_EN
        check_eq("sales_count", 32'(sales_count), m_sales);
        check_eq("refund_count", 32'(refund_count), m_refunds);
`endif
    endtask

    // Check the outputs produced by the previous edge, then drive this cycle's inputs.
    task automatic step(int ch, int cv, int mo, int ca);
        @(negedge clk);
        compare_outputs();
        bus.choice     = 3'(ch);
        bus.coin_valid = 1'(cv);
        bus.money      = 4'(mo);
        bus.cancel     = 1'(ca);
        model_step(ch, cv, mo, ca);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        int ch, cv, mo, ca, quiet;
        bus.choice = '0; bus.coin_valid = 1'b0; bus.money = '0; bus.cancel = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        step(1, 0, 0, 0);  step(0, 1, 10, 0); idle(3);
        step(3, 0, 0, 0);  step(0, 1, 5, 0);  step(0, 1, 5, 0); step(0, 1, 10, 0); idle(4);
        step(4, 0, 0, 0);  step(0, 1, 10, 0); step(0, 0, 0, 1); idle(3);
        step(7, 0, 0, 0);  idle(2);
        step(1, 0, 0, 0);  step(0, 1, 3, 0);  step(0, 0, 0, 1); idle(2);
        step(1, 0, 0, 0);  step(0, 1, 5, 0);  idle(TIMEOUT + 3);
        step(0, 1, 10, 0); idle(1);

        // Asynchronous reset in COLLECT with credit 5, checked between clock edges.
        step(1, 0, 0, 0);  step(0, 1, 5, 0);  step(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_states", 32'(bus.states), 0);
        check_eq("rst_credit", 32'(bus.credit), 0);
        check_eq("rst_delivery", 32'(bus.delivery), 0);
        check_eq("rst_change", 32'(bus.change), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        quiet = 0;
        for (int n = 0; n < 1500; n++) begin
            ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
            if (quiet > 0) begin
                cv = 0;
                quiet--;
            end else begin
                cv = int'($urandom_range(0, 1));
                if ($urandom_range(0, 30) == 0) quiet = 12;
            end
            mo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                             : (($urandom_range(0, 1) == 1) ? 10 : 5);
            ca = ($urandom_range(0, 24) == 0) ? 1 : 0;
            step(ch, cv, mo, ca);
        end
        idle(4);
        @(negedge clk);
        compare_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the two-product vending FSM. Supports NUM_PRODUCTS products with a per-product price table and a running credit accumulator over Rs.5/Rs.10 coins. Adds cancel/refund, an inactivity timeout, and multi-cycle change payout. Sits between the coin acceptor/keypad front end and the dispenser/coin-return actuators.

Parameters:
NUM_PRODUCTS, 4, number of selectable products; valid codes 1..NUM_PRODUCTS, 0 = no choice
SEL_W, 3, width of choice and product_id; must satisfy 2**SEL_W > NUM_PRODUCTS
CREDIT_W, 6, width of the credit accumulator and each price entry
PRICES, {6'd20,6'd15,6'd5,6'd10}, packed price table; product k at bits [k*CREDIT_W-1 -: CREDIT_W]; every price is a nonzero multiple of 5 and is at most 2**CREDIT_W-1-5
TIMEOUT_CYCLES, 100, idle cycles in COLLECT before auto-refund; must be at least 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
choice  in  SEL_W  product select; sampled only in IDLE
coin_valid  in  1  money is valid this cycle
money  in  4  coin value; legal values 4'b0101 (Rs.5) and 4'b1010 (Rs.10)
cancel  in  1  abort transaction and refund credit
delivery  out  1  dispense strobe; 1 cycle per sale
product_id  out  SEL_W  latched product; valid while delivery=1
change_valid  out  1  one coin returned this cycle
change  out  4  value of the returned coin (0101 or 1010); 0000 when change_valid=0
coin_reject  out  1  1-cycle pulse when an illegal or ignored coin is returned
credit  out  CREDIT_W  current accumulated credit
states  out  3  FSM state

Behaviour:
- Reset (reset=0, async): state IDLE; credit, product_id, timeout counter, and all strobes cleared; change=0000.
- States: IDLE=000, COLLECT=001, DISPENSE=010, CHANGE=011. All other encodings return to IDLE.
- Outputs are registered or decoded from registered state. The response appears in the cycle after the sampling edge.
- IDLE:
  - choice in 1..NUM_PRODUCTS: latch product_id, credit=0, go to COLLECT.
  - choice=0 or out of range: stay in IDLE.
  - Any coin_valid in IDLE: coin_reject pulse, no credit change.
- COLLECT:
  - Legal coin: credit += coin value, timeout counter cleared.
  - Illegal money with coin_valid=1: coin_reject pulse, credit unchanged, counter not cleared.
  - After the add, if credit >= price: go to DISPENSE.
  - cancel=1: go to CHANGE with credit intact. Cancel wins over a coin in the same cycle; that coin is not accepted and coin_reject pulses.
  - Counter reaches TIMEOUT_CYCLES with no legal coin: go to CHANGE (refund). If credit=0, go to IDLE instead.
  - choice changes in COLLECT are ignored.
- DISPENSE (1 cycle):
  - delivery=1, product_id held, credit -= price.
  - Next state is CHANGE if the remainder is >0, else IDLE.
  - Coins arriving here get a coin_reject pulse.
- CHANGE:
  - Each cycle: change_valid=1; change=1010 if credit>=10, else 0101; credit decremented by that value.
  - When credit reaches 0: go to IDLE.
  - cancel ignored; coins rejected.
- Credit never exceeds price+5, so there is no overflow. Width violation of PRICES is a static misconfiguration and is not checked at runtime.
- Reset asserted mid-transaction: credit is lost and no refund is issued (the front end handles this).

Optional Feature:
- Macro VM_SALES_COUNT_EN.
- Defined:
  - Adds output sales_count [15:0]: increments on every delivery cycle, saturates at 16'hFFFF, cleared by reset.
  - Adds output refund_count [15:0]: increments on each cancel- or timeout-initiated entry into CHANGE, same saturation and reset rules.
- Undefined: neither port exists; no counter logic is built.

Test Plan:
- Product 1 (price 10), single Rs.10: one cycle after the coin edge, delivery=1 and product_id=1; then IDLE with credit=0 and no change_valid.
- Product 3 (price 15), three coins Rs.5 / Rs.5 / Rs.10: credit goes 5, 10, 20; delivery pulse; one change cycle with change=0101; then IDLE.
- Product 4 (price 20), Rs.10 then cancel: CHANGE state, one cycle of change=1010, no delivery; IDLE after.
- Invalid inputs:
  - choice=3'b111: stays IDLE.
  - choice=1, then money=0011 with coin_valid=1: coin_reject pulse, credit=0, no delivery.
- Timeout (TIMEOUT_CYCLES=8), product 1 with a Rs.5 coin, then idle: after 8 cycles, change=0101 for one cycle, then IDLE.
- Reset low mid-COLLECT (credit=5): states=000, credit=0, delivery=0, change=0000 immediately, without waiting for a clock edge. With VM_SALES_COUNT_EN defined, sales_count increments by exactly 1 per delivery across the tests above.
